icache_fetch_responder: RTL and testbench
=========================================

// Module: icache_fetch_responder
// PURPOSE
//  Instruction-side responder to the program counter. Takes the fetch address (pc) and returns
//  the instruction word. Raises stall on a miss so the PC holds while a line refills.
//  Direct-mapped, read-only cache between the fetch stage and main memory.
//  A miss refills one full line from memory over a req/ready + rvalid handshake.
// PARAMETERS
//  LINE_WORDS  4   32-bit words per line; power of 2, >=2
//  NUM_LINES   16  lines in cache; power of 2
//  ADDR_W      32  address width
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  areset     in   1       reset: synchronous, active-high
//  pc         in   ADDR_W  fetch address; bits [1:0] ignored
//  flush      in   1       invalidate all lines (1-cycle pulse)
//  instr      out  32      instruction at pc; valid when stall==0
//  stall      out  1       1 = instr not valid; PC must hold
//  mem_req    out  1       line read request
//  mem_addr   out  ADDR_W  line-aligned refill address
//  mem_ready  in   1       memory accepts request this cycle
//  mem_rvalid in   1       mem_rdata carries next sequential word of line
//  mem_rdata  in   32      refill data word
// BEHAVIOUR
//  - Address split: off=pc[log2(LINE_WORDS)+1:2], idx=next log2(NUM_LINES) bits, tag=remaining upper bits.
//  - Hit = valid[idx] && tag_q[idx]==tag && state==IDLE.
//    On hit: instr=data[idx][off] combinationally, stall=0 in the same cycle (0-cycle latency).
//  - stall = !hit, combinational. It is also 1 in every non-IDLE state.
//  - FSM states: IDLE, REQ, FILL.
//    IDLE->REQ on miss; latch line address = {tag,idx,0}.
//    REQ: mem_req=1, mem_addr stable; ->FILL on the cycle mem_ready=1.
//    FILL: each mem_rvalid writes word[cnt], cnt++. mem_rvalid gaps allowed.
//    On the LINE_WORDS-th word: write tag, set valid, ->IDLE.
//  - Post-refill: the first IDLE cycle after a refill hits if pc is unchanged (miss penalty = req wait + words + 1).
//  - mem_rvalid outside FILL: ignored.
//    mem_req: never asserted outside REQ; deasserted the cycle after the handshake.
//  - Flush:
//    IDLE: clears all valid bits next cycle; the current-cycle lookup is unaffected.
//    REQ/FILL: recorded in flush_pend. Refill completes, but the line is NOT validated.
//    All valid bits are cleared at return to IDLE, then flush_pend is cleared.
//  - pc change during REQ/FILL: ignored. The refill of the latched line finishes; pc is re-looked-up in IDLE.
//  - Reset (any state, incl. mid-refill):
//    state=IDLE, all valid=0, cnt=0, flush_pend=0, mem_req=0.
//    Tag/data arrays are not cleared. A partial line is never validated.
//    Outputs after reset: stall=1 (cold miss); instr is don't-care.
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//    Adds outputs hit_cnt[31:0] and miss_cnt[31:0]; both reset to 0 and wrap at 2^32.
//    hit_cnt increments each IDLE hit cycle.
//    miss_cnt increments on each IDLE->REQ transition.
//  ICACHE_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  - icache_pkg:
//    state_t enum (IDLE, REQ, FILL).
//    localparam functions for OFF_W, IDX_W, TAG_W from LINE_WORDS, NUM_LINES, ADDR_W.
//  - Sub-module icache_line_store:
//    tag/valid/data arrays, 1 async read port, 1 word write port.
//    Provides valid clear-all (for flush/reset) and line validate.
//  - Top: FSM, refill counter, flush_pend, optional stats.
// TESTING
//  1. Reset then pc=0x0 -> stall=1, mem_req=1, mem_addr=0x0.
//     Then ready=1 and 4 rvalid words 0xA0..0xA3 -> next IDLE cycle: stall=0, instr=0xA0.
//  2. After test 1, pc=0x8 -> same-cycle hit, instr=0xA2, no mem_req.
//  3. Conflict: pc=0x100 (same idx 0, new tag) -> refill with 0xB0..B3, instr=0xB0.
//     Then pc=0x0 -> misses again.
//  4. Flush pulse mid-FILL of line 0x40 -> FILL completes, stall stays 1.
//     Back in IDLE with pc=0x40 -> a new miss issues mem_req again.
//  5. areset=1 after 2 of 4 rvalid words -> mem_req=0, state IDLE.
//     Re-fetching the same pc misses and does a full 4-word refill.
//  6. mem_rvalid gaps (1 word every 3 cycles) and mem_ready delayed 5 cycles -> correct data.
//     stall is held throughout; with ICACHE_STATS_EN, miss_cnt=1, hit_cnt counts hit cycles only.

Source files
------------

// File: rtl/icache_fetch_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_fetch_responder_pkg
// Brief    : Shared FSM state type and address-field width helpers for the
//            direct-mapped instruction cache.
// Revision : 1.0
// ============================================================================
package icache_fetch_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } state_t;

    function automatic int f_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int f_idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag is whatever remains above the word offset, line offset and index.
    function automatic int f_tag_w(input int addr_w, input int line_words, input int num_lines);
        return addr_w - 2 - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_fetch_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_fetch_responder_if
// Brief    : Fetch-side and refill-side signals of the instruction cache.
//            ICACHE_STATS_EN adds the hit/miss counter outputs.
// Revision : 1.0
// ============================================================================
interface icache_fetch_responder_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic [31:0]       instr;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    modport slave (
        input  pc, flush, mem_ready, mem_rvalid, mem_rdata,
        output instr, stall, mem_req, mem_addr, hit_cnt, miss_cnt
    );
    modport master (
        output pc, flush, mem_ready, mem_rvalid, mem_rdata,
        input  instr, stall, mem_req, mem_addr, hit_cnt, miss_cnt
    );
`else
    modport slave (
        input  pc, flush, mem_ready, mem_rvalid, mem_rdata,
        output instr, stall, mem_req, mem_addr
    );
    modport master (
        output pc, flush, mem_ready, mem_rvalid, mem_rdata,
        input  instr, stall, mem_req, mem_addr
    );
`endif
endinterface
`default_nettype wire

// File: rtl/icache_fetch_responder_line_store.sv
`default_nettype none
// ============================================================================
// Module   : icache_fetch_responder_line_store
// Brief    : Tag/valid/data arrays with one async read port, one word write
//            port, a line-validate strobe and a clear-all for the valid bits.
// Revision : 1.0
// ============================================================================
module icache_fetch_responder_line_store #(
    parameter int OFF_W = 2,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_all_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [OFF_W-1:0] rd_off_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [OFF_W-1:0] wr_off_i,
    input  logic [31:0]      wr_data_i,
    input  logic             tag_wr_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             validate_i
);
    localparam int LINES = 1 << IDX_W;
    localparam int DEPTH = 1 << (IDX_W + OFF_W);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clr_all_i) begin
            valid_q <= '0;
        end else if (validate_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only the valid bits gate hits.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
        end
        if (tag_wr_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];

endmodule
`default_nettype wire

// File: rtl/icache_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : icache_fetch_responder
// Brief    : Direct-mapped read-only instruction cache with 0-cycle hits and a
//            whole-line refill FSM. ICACHE_STATS_EN adds hit/miss counters.
// Revision : 1.0
// ============================================================================
module icache_fetch_responder
    import icache_fetch_responder_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    areset,
    icache_fetch_responder_if.slave bus
);
    localparam int OFF_W  = f_off_w(LINE_WORDS);
    localparam int IDX_W  = f_idx_w(NUM_LINES);
    localparam int TAG_W  = f_tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
    localparam int LINE_W = TAG_W + IDX_W;

    state_t              state_q, state_d;
    logic [OFF_W-1:0]    cnt_q;
    logic                flush_pend_q;
    logic [LINE_W-1:0]   line_q;

    logic [OFF_W-1:0]    w_off;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_rd_valid;
    logic [TAG_W-1:0]    w_rd_tag;
    logic [31:0]         w_rd_data;
    logic                w_hit;
    logic                w_last;
    logic                w_flush_seen;
    logic                w_stall;
    logic                w_mem_req;
    logic                w_wr_en;
    logic                w_tag_wr;
    logic                w_validate;
    logic                w_clr_all;
    logic                w_unused_pc;

    assign w_off       = bus.pc[OFF_W+1:2];
    assign w_idx       = bus.pc[OFF_W+IDX_W+1:OFF_W+2];
    assign w_tag       = bus.pc[ADDR_W-1:OFF_W+IDX_W+2];
    assign w_unused_pc = ^bus.pc[1:0];

    assign w_hit        = (state_q == S_IDLE) && w_rd_valid && (w_rd_tag == w_tag);
    assign w_last       = (state_q == S_FILL) && bus.mem_rvalid && (&cnt_q);
    assign w_flush_seen = flush_pend_q | bus.flush;

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!w_hit)          state_d = S_REQ;
            S_REQ:   if (bus.mem_ready)   state_d = S_FILL;
            S_FILL:  if (w_last)          state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // A flush seen at any point of a refill keeps that line invalid and wipes
    // every valid bit as the FSM returns to IDLE.
    always_comb begin
        w_stall    = !w_hit;
        w_mem_req  = (state_q == S_REQ);
        w_wr_en    = (state_q == S_FILL) && bus.mem_rvalid;
        w_tag_wr   = w_last;
        w_validate = w_last && !w_flush_seen;
        w_clr_all  = ((state_q == S_IDLE) && bus.flush) || (w_last && w_flush_seen);
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (w_wr_en) begin
                cnt_q <= cnt_q + OFF_W'(1);
            end
            if (w_last) begin
                flush_pend_q <= 1'b0;
            end else if ((state_q != S_IDLE) && bus.flush) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && !w_hit) begin
            line_q <= {w_tag, w_idx};
        end
    end

    icache_fetch_responder_line_store #(
        .OFF_W (OFF_W),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_line_store (
        .clk        (clk),
        .rst        (areset),
        .clr_all_i  (w_clr_all),
        .rd_idx_i   (w_idx),
        .rd_off_i   (w_off),
        .rd_valid_o (w_rd_valid),
        .rd_tag_o   (w_rd_tag),
        .rd_data_o  (w_rd_data),
        .wr_en_i    (w_wr_en),
        .wr_idx_i   (line_q[IDX_W-1:0]),
        .wr_off_i   (cnt_q),
        .wr_data_i  (bus.mem_rdata),
        .tag_wr_i   (w_tag_wr),
        .wr_tag_i   (line_q[LINE_W-1:IDX_W]),
        .validate_i (w_validate)
    );

    assign bus.instr    = w_rd_data;
    assign bus.stall    = w_stall;
    assign bus.mem_req  = w_mem_req;
    assign bus.mem_addr = {line_q, {(OFF_W+2){1'b0}}};

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (areset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (w_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == S_IDLE) && !w_hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_fetch_responder
// Brief    : Self-checking bench: directed table, multi-cycle corner sequences
//            and randomized traffic against a line-residency reference model.
//            Also checks the counters when ICACHE_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
module tb_icache_fetch_responder;

    localparam int LW = 4;
    localparam int NL = 16;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    icache_fetch_responder_if #(.ADDR_W(AW)) ifc ();

    icache_fetch_responder #(
        .LINE_WORDS (LW),
        .NUM_LINES  (NL),
        .ADDR_W     (AW)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (ifc)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_ovr [logic [31:0]];

    // Reference model: which line address each index holds, plus refill progress.
    bit          m_busy, m_fill, m_pend;
    logic [31:0] m_lat;
    int          m_words;
    bit          m_valid [NL];
    logic [31:0] m_line  [NL];
    logic [31:0] m_hits, m_miss;
    int          dly_cnt, gap_cnt;
    int          ready_delay, gap;
    bit          mem_rand;

    logic        s_stall, s_req;
    logic [31:0] s_instr, s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        if (mem_ovr.exists(w)) return mem_ovr[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(LW*4 - 1);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32'(LW*4)) % 32'(NL));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_valid();
        for (int k = 0; k < NL; k++) m_valid[k] = 1'b0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_fill = 0; m_pend = 0; m_words = 0;
        m_hits = '0; m_miss = '0; dly_cnt = 0; gap_cnt = 0;
        clear_valid();
    endtask

    // One clock: drive memory side, sample at negedge, compare, advance model.
    task automatic step();
        int  i;
        bit  exp_hit;
        i = idx_of(ifc.pc);
        exp_hit = !m_busy && m_valid[i] && (m_line[i] == line_of(ifc.pc));

        ifc.mem_ready  = ($urandom_range(0, 3) == 0);
        ifc.mem_rvalid = ($urandom_range(0, 3) == 0);
        ifc.mem_rdata  = $urandom;
        if (m_busy && !m_fill) begin
            ifc.mem_ready = mem_rand ? ($urandom_range(0, 2) == 0) : (dly_cnt >= ready_delay);
        end else if (m_busy) begin
            ifc.mem_rvalid = mem_rand ? ($urandom_range(0, 1) == 0) : (gap_cnt >= gap);
            if (ifc.mem_rvalid) ifc.mem_rdata = mem_word(m_lat + 32'(4*m_words));
        end

        @(negedge clk);
        s_stall = ifc.stall;
        s_req   = ifc.mem_req;
        s_instr = ifc.instr;
        s_addr  = ifc.mem_addr;

        if (!m_busy) begin
            check("stall_idle", 32'(s_stall), 32'(!exp_hit));
            if (exp_hit) check("instr", s_instr, mem_word(ifc.pc));
            check("mem_req_idle", 32'(s_req), 32'd0);
        end else begin
            check("stall_busy", 32'(s_stall), 32'd1);
            check("mem_req_busy", 32'(s_req), 32'(!m_fill));
            if (!m_fill) check("mem_addr", s_addr, m_lat);
        end
`ifdef ICACHE_STATS_EN
        check("hit_cnt", ifc.hit_cnt, m_hits);
        check("miss_cnt", ifc.miss_cnt, m_miss);
`endif

        if (areset) begin
            model_reset();
        end else if (!m_busy) begin
            if (exp_hit) m_hits++;
            if (ifc.flush) clear_valid();
            if (!exp_hit) begin
                m_busy = 1; m_fill = 0; m_lat = line_of(ifc.pc);
                m_words = 0; dly_cnt = 0; m_miss++;
            end
        end else begin
            if (ifc.flush) m_pend = 1;
            if (!m_fill) begin
                if (ifc.mem_ready) begin m_fill = 1; gap_cnt = 0; end
                else dly_cnt++;
            end else if (ifc.mem_rvalid) begin
                m_words++;
                gap_cnt = 0;
                if (m_words == LW) begin
                    m_busy = 0;
                    if (m_pend) begin clear_valid(); m_pend = 0; end
                    else begin m_valid[idx_of(m_lat)] = 1; m_line[idx_of(m_lat)] = m_lat; end
                end
            end else begin
                gap_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, output bit missed,
                         output logic [31:0] data, output int stall_cycles);
        int n;
        ifc.pc = a;
        step();
        missed = s_stall;
        stall_cycles = s_stall ? 1 : 0;
        n = 0;
        while (s_stall && n < 300) begin
            step();
            if (s_stall) stall_cycles++;
            n++;
        end
        if (s_stall) begin
            checks++; failures++;
            $display("FAIL fetch_timeout pc=%h actual=stalled required=hit", a);
        end
        data = s_instr;
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          exp_miss;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          missed;
        logic [31:0] data;
        int          sc, n;

        ifc.pc = '0; ifc.flush = 1'b0; ifc.mem_ready = 1'b0;
        ifc.mem_rvalid = 1'b0; ifc.mem_rdata = '0;
        ready_delay = 0; gap = 0; mem_rand = 0;
        for (int k = 0; k < LW; k++) begin
            mem_ovr[32'(4*k)]         = 32'hA0 + 32'(k);
            mem_ovr[32'h100 + 32'(4*k)] = 32'hB0 + 32'(k);
        end
        for (int k = 0; k < NL; k++) m_line[k] = '0;

        tbl[0] = '{32'h000, 1'b1, 32'hA0};
        tbl[1] = '{32'h008, 1'b0, 32'hA2};
        tbl[2] = '{32'h00C, 1'b0, 32'hA3};
        tbl[3] = '{32'h100, 1'b1, 32'hB0};
        tbl[4] = '{32'h104, 1'b0, 32'hB1};
        tbl[5] = '{32'h000, 1'b1, 32'hA0};
        tbl[6] = '{32'h108, 1'b1, 32'hB2};

        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();
        areset = 1'b0;
        check("reset_stall", 32'(s_stall), 32'd1);
        check("reset_mem_req", 32'(s_req), 32'd0);

        // Directed fetches: cold miss, hits within a line, index conflicts.
        for (int v = 0; v < 7; v++) begin
            fetch(tbl[v].pc, missed, data, sc);
            check("tbl_miss", 32'(missed), 32'(tbl[v].exp_miss));
            check("tbl_instr", data, tbl[v].exp_instr);
            if (v == 0) check("cold_penalty", 32'(sc), 32'd6);
        end

        // Flush mid-FILL: line completes but stays invalid.
        ifc.pc = 32'h40;
        n = 0;
        while (!(m_busy && m_fill && m_words >= 1) && n < 50) begin step(); n++; end
        ifc.flush = 1'b1;
        step();
        ifc.flush = 1'b0;
        n = 0;
        while (m_busy && n < 50) begin step(); n++; end
        step();
        check("flush_line_invalid", 32'(s_stall), 32'd1);
        step();
        check("flush_rereq", 32'(s_req), 32'd1);
        fetch(32'h40, missed, data, sc);
        check("flush_refetch_instr", data, mem_word(32'h40));

        // Reset after two of four refill words.
        ifc.pc = 32'h80;
        n = 0;
        while (!(m_fill && m_words == 2) && n < 50) begin step(); n++; end
        areset = 1'b1;
        step();
        areset = 1'b0;
        step();
        check("rst_mid_mem_req", 32'(s_req), 32'd0);
        check("rst_mid_stall", 32'(s_stall), 32'd1);
        fetch(32'h80, missed, data, sc);
        check("rst_refetch_instr", data, mem_word(32'h80));
        fetch(32'h8C, missed, data, sc);
        check("rst_full_line_hit", 32'(missed), 32'd0);
        check("rst_full_line_instr", data, mem_word(32'h8C));

        // Slow memory: ready after 5 wait cycles, one word every 3 cycles.
        ready_delay = 5; gap = 2;
        fetch(32'h204, missed, data, sc);
        check("slow_miss", 32'(missed), 32'd1);
        check("slow_instr", data, mem_word(32'h204));
        check("slow_penalty", 32'(sc), 32'd19);
        ready_delay = 0; gap = 0;

        // Randomized traffic: pc churn during refills, flushes and resets.
        mem_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                ifc.pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, NL-1)) << 4)
                       | 32'($urandom_range(0, 15));
            end
            ifc.flush = ($urandom_range(0, 24) == 0);
            areset    = ($urandom_range(0, 199) == 0);
            step();
        end
        areset = 1'b0;
        ifc.flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
